// File: rtl/ad_rx_capture.sv
// I/Q ADC receive capture: 3-stage sample pipeline, triggered fixed-length frame FSM, FWFT FIFO.
// Optional DC removal on stage 3 is enabled by defining DC_REMOVE_EN.
module ad_rx_capture #(
  parameter int FIFO_AW  = 9,
  parameter int LEN_W    = 16,
  parameter int DC_SHIFT = 10
) (
  input  logic               clk163m84,
  input  logic               rst_n,
  input  logic [11:0]        adc_dat_i,
  input  logic [11:0]        adc_dat_q,
  input  logic               cfg_offset_bin,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               start,
  input  logic               trig,
  input  logic               abort,
  output logic [31:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  // ---------------- sample pipeline ----------------
  logic [11:0] s1_i_q, s1_q_q, s1_i_d, s1_q_d;
  logic [11:0] s2_i_q, s2_q_q, s2_i_d, s2_q_d;
  logic [11:0] s3_i_q, s3_q_q, s3_i_d, s3_q_d;

  always_comb begin
    s1_i_d = adc_dat_i;
    s1_q_d = adc_dat_q;
    s2_i_d = {s1_i_q[11] ^ cfg_offset_bin, s1_i_q[10:0]};
    s2_q_d = {s1_q_q[11] ^ cfg_offset_bin, s1_q_q[10:0]};
  end

`ifdef DC_REMOVE_EN
  localparam int ACC_W = 12 + DC_SHIFT;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;

  function automatic logic signed [ACC_W-1:0] acc_next(input logic signed [ACC_W-1:0] acc,
                                                       input logic [11:0] x);
    logic signed [ACC_W-1:0] xe;
    xe = {{DC_SHIFT{x[11]}}, x};
    return acc + xe - (acc >>> DC_SHIFT);
  endfunction

  // Tracked DC estimate fits in 12 bits; the 13-bit difference is clamped back to 12.
  function automatic logic [11:0] dc_out(input logic signed [ACC_W-1:0] acc,
                                         input logic [11:0] x);
    logic signed [ACC_W-1:0] sh;
    logic signed [12:0]      d;
    sh = acc >>> DC_SHIFT;
    d  = $signed({x[11], x}) - $signed({sh[11], sh[11:0]});
    if (d[12] != d[11]) return d[12] ? 12'h800 : 12'h7FF;
    return d[11:0];
  endfunction

  always_comb begin
    acc_i_d = acc_next(acc_i_q, s2_i_q);
    acc_q_d = acc_next(acc_q_q, s2_q_q);
    s3_i_d  = dc_out(acc_i_q, s2_i_q);
    s3_q_d  = dc_out(acc_q_q, s2_q_q);
  end

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end
`else
  always_comb begin
    s3_i_d = s2_i_q;
    s3_q_d = s2_q_q;
  end
`endif

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      s1_i_q <= '0; s1_q_q <= '0;
      s2_i_q <= '0; s2_q_q <= '0;
      s3_i_q <= '0; s3_q_q <= '0;
    end else begin
      s1_i_q <= s1_i_d; s1_q_q <= s1_q_d;
      s2_i_q <= s2_i_d; s2_q_q <= s2_q_d;
      s3_i_q <= s3_i_d; s3_q_q <= s3_q_d;
    end
  end

  // ---------------- frame FSM ----------------
  logic [1:0]       st_q, st_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             ovf_q, ovf_d, done_q, done_d;
  logic [FIFO_AW:0] fifo_cnt_q, fifo_cnt_d;
  logic             full, cap, push, push_last, pop;

  assign full = (fifo_cnt_q == FULL_CNT);

  always_comb begin
    st_d      = st_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    cap       = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (st_q)
      ST_IDLE: if (start && !abort && frame_len != '0) begin
        st_d  = ST_ARM;
        len_d = frame_len;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      ST_ARM:  if (abort) st_d = ST_IDLE; else cap = trig;
      ST_CAPT: if (abort) st_d = ST_IDLE; else cap = 1'b1;
      default: st_d = ST_IDLE;
    endcase
    // The trigger cycle itself captures frame sample 0.
    if (cap) begin
      if (full) begin
        ovf_d = 1'b1;
        st_d  = ST_IDLE;
      end else begin
        push = 1'b1;
        if (cnt_q == len_q - LEN_W'(1)) begin
          push_last = 1'b1;
          done_d    = 1'b1;
          st_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
          st_d  = ST_CAPT;
        end
      end
    end
  end

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      len_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [32:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [32:0]        rd_entry;

  assign rd_entry = mem_q[rd_ptr_q];
  assign pop      = m_valid && m_ready;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (FIFO_AW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (FIFO_AW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk163m84) begin
    if (push)
      mem_q[wr_ptr_q] <= {push_last, {4{s3_q_q[11]}}, s3_q_q, {4{s3_i_q[11]}}, s3_i_q};
  end

  always_ff @(posedge clk163m84 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Gate the read port so an empty FIFO presents zeros rather than stale RAM.
  assign m_valid  = (fifo_cnt_q != '0);
  assign m_data   = m_valid ? rd_entry[31:0] : 32'h0;
  assign m_last   = m_valid & rd_entry[32];
  assign busy     = (st_q != ST_IDLE);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign fifo_cnt = fifo_cnt_q;

endmodule

// File: tb/tb_ad_rx_capture.sv
// Directed bench for ad_rx_capture: default-depth instance plus a 4-entry FIFO instance.
module tb_ad_rx_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_i, adc_q;
  logic        cfg;
  logic [15:0] frame_len;
  logic        start, trig, abort, m_ready;

  logic [31:0] m_data;   logic m_valid, m_last, busy, done, ovf;   logic [9:0] fifo_cnt;
  logic [31:0] s_data;   logic s_valid, s_last, s_busy, s_done, s_ovf; logic [2:0] s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ad_rx_capture u_dut (
    .clk163m84(clk), .rst_n(rst_n), .adc_dat_i(adc_i), .adc_dat_q(adc_q),
    .cfg_offset_bin(cfg), .frame_len(frame_len), .start(start), .trig(trig), .abort(abort),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .ovf(ovf), .fifo_cnt(fifo_cnt));

  ad_rx_capture #(.FIFO_AW(2)) u_small (
    .clk163m84(clk), .rst_n(rst_n), .adc_dat_i(adc_i), .adc_dat_q(adc_q),
    .cfg_offset_bin(cfg), .frame_len(frame_len), .start(start), .trig(trig), .abort(abort),
    .m_data(s_data), .m_valid(s_valid), .m_ready(m_ready), .m_last(s_last),
    .busy(s_busy), .done(s_done), .ovf(s_ovf), .fifo_cnt(s_cnt));

  typedef struct {
    logic        ofs;
    logic [11:0] i;
    logic [11:0] q;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; trig = 1'b0; abort = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single-sample frame with pins held constant for 'pre' cycles beforehand.
  task automatic cap_one(input logic ofs, input logic [11:0] i, input logic [11:0] q, input int pre,
                         output logic [31:0] d, output logic l, output logic dn, output logic ok);
    @(posedge clk); #1 cfg = ofs; adc_i = i; adc_q = q; m_ready = 1'b0; trig = 1'b0;
    repeat (pre) @(posedge clk);
    #1 frame_len = 16'd1; start = 1'b1; trig = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (m_valid) ok = 1'b1;
    end
    d = m_data; l = m_last; dn = done;
    @(posedge clk); #1 m_ready = 1'b1; trig = 1'b0;
    @(posedge clk); #1 m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        l, dn, ok;
    logic [15:0] ent [8];
    logic [7:0]  lst;
    int          n_ent, nd, b6, b7, ov3;
    logic        bseen;
    int          iv;

    vt[0] = '{1'b0, 12'h001, 12'h000, 32'h0000_0001};
    vt[1] = '{1'b0, 12'h7FF, 12'h800, 32'hF800_07FF};
    vt[2] = '{1'b1, 12'h000, 12'hFFF, 32'h07FF_F800};
    vt[3] = '{1'b1, 12'h800, 12'h7FF, 32'hFFFF_0000};
    vt[4] = '{1'b0, 12'hABC, 12'h123, 32'h0123_FABC};
    vt[5] = '{1'b1, 12'h123, 12'hABC, 32'h02BC_F923};

    adc_i = '0; adc_q = '0; cfg = 1'b0; frame_len = '0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_cnt",   32'(fifo_cnt), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_last",  32'(m_last), 0);
    chk("rst_data",  m_data, 0);

    // frame of 4 with ramp, consumer always ready
    do_reset();
    m_ready = 1'b1; frame_len = 16'd4; trig = 1'b1; cfg = 1'b0;
    n_ent = 0; nd = 0; bseen = 1'b0; lst = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 adc_i = 12'(c + 1); start = (c == 2);
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (n_ent < 8) begin ent[n_ent] = m_data[15:0]; lst[n_ent] = m_last; end
        n_ent++;
      end
      if (done) nd++;
      if (busy) bseen = 1'b1;
    end
    chk("t1_entries", 32'(n_ent), 4);
    for (int k = 0; k < 4; k++) chk("t1_sample", 32'(ent[k]), 32'(k + 1));
    chk("t1_last",  32'(lst[3:0]), 32'h8);
    chk("t1_done",  32'(nd), 1);
    chk("t1_busy_seen", 32'(bseen), 1);
    chk("t1_busy_end",  32'(busy), 0);

    // overflow on the 4-entry FIFO
    do_reset();
    m_ready = 1'b0; frame_len = 16'd10; trig = 1'b1;
    nd = 0; bseen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1 adc_i = 12'(c + 1); start = (c == 2);
      @(negedge clk);
      if (s_done) nd++;
      if (s_last) bseen = 1'b1;
    end
    chk("t3_cnt",  32'(s_cnt), 4);
    chk("t3_ovf",  32'(s_ovf), 1);
    chk("t3_done", 32'(nd), 0);
    chk("t3_busy", 32'(s_busy), 0);
    @(posedge clk); #1 m_ready = 1'b1;
    n_ent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_valid && m_ready) begin
        if (n_ent < 8) ent[n_ent] = s_data[15:0];
        n_ent++;
      end
      if (s_last) bseen = 1'b1;
      @(posedge clk);
    end
    chk("t3_drained", 32'(n_ent), 4);
    for (int k = 0; k < 4; k++) chk("t3_sample", 32'(ent[k]), 32'(k + 1));
    chk("t3_no_last", 32'(bseen), 0);
    chk("t3_empty",   32'(s_cnt), 0);

    // abort on the third CAPT cycle; start also clears the sticky ovf
    #1 m_ready = 1'b0; frame_len = 16'd8; trig = 1'b1;
    nd = 0; b6 = 0; b7 = 0; ov3 = 1; bseen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 adc_i = 12'(c + 1); start = (c == 2); abort = (c == 6);
      @(negedge clk);
      if (s_done) nd++;
      if (s_last) bseen = 1'b1;
      if (c == 3) ov3 = 32'(s_ovf);
      if (c == 6) b6 = 32'(s_busy);
      if (c == 7) b7 = 32'(s_busy);
    end
    chk("t4_busy_abort", 32'(b6), 1);
    chk("t4_idle_next",  32'(b7), 0);
    chk("t4_cnt",  32'(s_cnt), 3);
    chk("t4_ovf",  32'(s_ovf), 0);
    chk("t4_ovf_cleared", 32'(ov3), 0);
    chk("t4_done", 32'(nd), 0);
    chk("t4_no_last", 32'(bseen), 0);
    chk("t4_head", 32'(s_data[15:0]), 1);

    // asynchronous reset mid-frame
    do_reset();
    m_ready = 1'b0; frame_len = 16'd8; trig = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 adc_i = 12'(c + 1); start = (c == 2);
      @(negedge clk);
    end
    chk("t5_busy_pre",  32'(busy), 1);
    chk("t5_valid_pre", 32'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_cnt",   32'(fifo_cnt), 0);
    chk("t5_busy",  32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0; trig = 1'b0;

    // sample format conversion table
    for (int k = 0; k < 6; k++) begin
      cap_one(vt[k].ofs, vt[k].i, vt[k].q, 4, d, l, dn, ok);
      chk("vec_valid", 32'(ok), 1);
`ifndef DC_REMOVE_EN
      chk("vec_data", d, vt[k].exp);
`endif
      chk("vec_last", 32'(l), 1);
      chk("vec_done", 32'(dn), 1);
    end

    // constant input through the DC stage
    do_reset();
    cap_one(1'b0, 12'h100, 12'h100, 8 * 1024, d, l, dn, ok);
    chk("t6_valid", 32'(ok), 1);
`ifdef DC_REMOVE_EN
    iv = int'($signed(d[11:0]));
    if (iv < 0) iv = -iv;
    chk("t6_dc_small", 32'(iv < 16), 1);
`else
    chk("t6_passthru", d, 32'h0100_0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
